// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and constants for the LED sequencer controller.
//   mode_e   : pattern modes (binary count, walking one, bouncing one, hold)
//   state_e  : handshake / run control states
//   PAT_*    : initial patterns loaded when a mode is entered
//   DIR_*    : travel direction of the bouncing one
// -----------------------------------------------------------------------------
package led_seq_pkg;

  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  localparam logic [LED_W-1:0] PAT_ZERO = 16'h0000;
  localparam logic [LED_W-1:0] PAT_ONE  = 16'h0001;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_seq_prescaler.sv
// -----------------------------------------------------------------------------
// led_seq_prescaler
// WIDTH-bit up counter producing one tick every 2^WIDTH enabled cycles.
// Holding en_i low pauses the count without losing the partial period.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : count enable
//   clr_i      : synchronous clear (has priority over en_i)
//   tick_o     : high in the enabled cycle where the counter is all-ones
// -----------------------------------------------------------------------------
module led_seq_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [WIDTH-1:0] cnt_q;

  assign tick_o = en_i & (&cnt_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);  // wraps to 0 right after the tick
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// Sequences a 16-bit LED pattern (count / walking one / bouncing one / hold)
// with a prescaled advance rate and a 4-phase req/ack mode-change handshake.
//   clk, rst_n : system clock, asynchronous active-low reset
//   run        : 1 = advance pattern, 0 = pause (prescaler keeps its value)
//   mode_req   : mode-change request, held until mode_ack is seen
//   mode_sel   : requested mode, stable while mode_req=1
//   duty       : PWM duty (only with LED_SEQ_PWM_EN defined)
//   mode_ack   : acknowledge, high exactly in ACK
//   mode_cur   : active mode
//   busy       : high in SWITCH and ACK
//   led        : LED pattern (gated by PWM when LED_SEQ_PWM_EN is defined)
// Build option: define LED_SEQ_PWM_EN to add the duty input and PWM dimming.
// -----------------------------------------------------------------------------
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LOG2DELAY = 8,
  parameter int BITS      = LED_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            mode_req,
  input  logic [1:0]      mode_sel,
`ifdef LED_SEQ_PWM_EN
  input  logic [3:0]      duty,
`endif
  output logic            mode_ack,
  output logic [1:0]      mode_cur,
  output logic            busy,
  output logic [BITS-1:0] led
);

  localparam logic [BITS-1:0] LED_MSB = {1'b1, {(BITS-1){1'b0}}};

  state_e            state_q, state_d;
  mode_e             mode_q,  mode_d;
  logic [BITS-1:0]   led_q,   led_d;
  logic              dir_q,   dir_d;
  logic              tick;

  led_seq_prescaler #(
    .WIDTH (LOG2DELAY)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == ST_RUN),
    .clr_i  (state_q == ST_SWITCH),
    .tick_o (tick)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    dir_d   = dir_q;

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (mode_req) begin
          state_d = ST_SWITCH;             // a coincident tick is dropped
        end else begin
          state_d = run ? ST_RUN : ST_IDLE;
          if (tick) begin
            unique case (mode_q)
              MODE_COUNT:  led_d = led_q + BITS'(1);
              MODE_SHIFT:  led_d = {led_q[BITS-2:0], led_q[BITS-1]};
              MODE_BOUNCE: begin
                // Reverse at the ends without repeating the end value.
                if (dir_q == DIR_LEFT) begin
                  if (led_q == LED_MSB) begin
                    dir_d = DIR_RIGHT;
                    led_d = led_q >> 1;
                  end else begin
                    led_d = led_q << 1;
                  end
                end else begin
                  if (led_q == BITS'(PAT_ONE)) begin
                    dir_d = DIR_LEFT;
                    led_d = led_q << 1;
                  end else begin
                    led_d = led_q >> 1;
                  end
                end
              end
              MODE_HOLD:   led_d = led_q;
            endcase
          end
        end
      end
      ST_SWITCH: begin
        mode_d = mode_e'(mode_sel);
        unique case (mode_e'(mode_sel))
          MODE_COUNT:  led_d = BITS'(PAT_ZERO);
          MODE_SHIFT:  led_d = BITS'(PAT_ONE);
          MODE_BOUNCE: begin
            led_d = BITS'(PAT_ONE);
            dir_d = DIR_LEFT;
          end
          MODE_HOLD:   led_d = led_q;
        endcase
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!mode_req) begin
          state_d = run ? ST_RUN : ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COUNT;
      led_q   <= BITS'(PAT_ZERO);
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign mode_ack = (state_q == ST_ACK);
  assign busy     = (state_q == ST_SWITCH) || (state_q == ST_ACK);
  assign mode_cur = mode_q;

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign led = (pwm_q < duty) ? led_q : '0;
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// Self-checking bench for led_seq_ctrl with LOG2DELAY=2. A behavioural model
// (pattern values as integers, bounce as a position index) predicts every
// output each cycle; directed steps cover wrap, rotate, bounce ends, pause,
// tick/request collision and reset during the handshake, followed by random
// run/request traffic.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

  localparam int L2D    = 2;
  localparam int PERIOD = 1 << L2D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        mode_ack;
  logic [1:0]  mode_cur;
  logic        busy;
  logic [15:0] led;
`ifdef LED_SEQ_PWM_EN
  logic [3:0]  duty = 4'd4;
`endif

  led_seq_ctrl #(.LOG2DELAY(L2D), .BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .mode_req (mode_req),
    .mode_sel (mode_sel),
`ifdef LED_SEQ_PWM_EN
    .duty     (duty),
`endif
    .mode_ack (mode_ack),
    .mode_cur (mode_cur),
    .busy     (busy),
    .led      (led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = normal (idle or running), 1 = switching, 2 = acknowledging
  int m_phase, m_in_run, m_presc, m_led, m_mode, m_pos, m_dir, m_pwm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_in_run = 0; m_presc = 0; m_led = 0;
    m_mode = 0; m_pos = 0; m_dir = 1; m_pwm = 0;
  endtask

  task automatic model_advance();
    case (m_mode)
      0: m_led = (m_led + 1) % 65536;
      1: m_led = ((m_led << 1) | (m_led >> 15)) & 'hFFFF;
      2: begin
        if (m_dir == 1 && m_pos == 15)     begin m_dir = -1; m_pos = 14; end
        else if (m_dir == -1 && m_pos == 0) begin m_dir = 1;  m_pos = 1;  end
        else m_pos = m_pos + m_dir;
        m_led = 1 << m_pos;
      end
      default: ;
    endcase
  endtask

  task automatic model_step();
    bit tick;
    if (m_phase == 0) begin
      tick = (m_in_run != 0) && (m_presc == PERIOD - 1);
      if (m_in_run != 0) m_presc = (m_presc + 1) % PERIOD;
      if (mode_req) m_phase = 1;
      else begin
        if (tick) model_advance();
        m_in_run = run;
      end
    end else if (m_phase == 1) begin
      m_mode  = mode_sel;
      m_presc = 0;
      case (m_mode)
        0: m_led = 0;
        1: m_led = 1;
        2: begin m_led = 1; m_pos = 0; m_dir = 1; end
        default: ;
      endcase
      m_phase = 2;
    end else if (!mode_req) begin
      m_phase  = 0;
      m_in_run = run;
    end
    m_pwm = (m_pwm + 1) % 16;
  endtask

  function automatic logic [15:0] exp_led();
`ifdef LED_SEQ_PWM_EN
    return (m_pwm < int'(duty)) ? 16'(m_led) : 16'h0000;
`else
    return 16'(m_led);
`endif
  endfunction

  task automatic check_outputs(input string where);
    check({where, ".led"},      {16'h0, led},      {16'h0, exp_led()});
    check({where, ".mode_cur"}, {30'h0, mode_cur}, m_mode);
    check({where, ".busy"},     {31'h0, busy},     {31'h0, m_phase != 0});
    check({where, ".mode_ack"}, {31'h0, mode_ack}, {31'h0, m_phase == 2});
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge.
  task automatic step(input string where = "cyc");
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(where);
  endtask

  // Full 4-phase handshake with a bounded wait for the acknowledge.
  task automatic request(input logic [1:0] mode, input int hold);
    mode_sel = mode;
    mode_req = 1'b1;
    for (int i = 0; i < 6 && mode_ack !== 1'b1; i++) step("req");
    check("ack_seen", {31'h0, mode_ack}, 32'd1);
    repeat (hold) step("ack_hold");
    mode_req = 1'b0;
    step("ack_exit");
  endtask

  int n;
  logic [15:0] prev_led;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Binary count from 0 at one step per PERIOD cycles
    run = 1'b1;
    repeat (3 * PERIOD + 3) step("count");

    // Preload 0xFFFF while paused, then watch the wrap to 0
    run = 1'b0;
    repeat (2) step("pause_pre");
    force dut.led_q = 16'hFFFF;
    m_led = 'hFFFF;
    step("force");
    release dut.led_q;
    run = 1'b1;
    repeat (2 * PERIOD + 2) step("wrap");

    // Walking one: full rotation through 0x8000 back to 0x0001
    request(2'd1, 2);
`ifndef LED_SEQ_PWM_EN
    prev_led = led;
    n = 0;
    while (led === prev_led && n < 20) begin step("latency"); n++; end
    check("first_step_latency", n, PERIOD);
`endif
    repeat (17 * PERIOD) step("shift");

    // Bouncing one over a full back-and-forth sweep
    request(2'd2, 1);
    repeat (32 * PERIOD) step("bounce");

    // Pause with prescaler at 2, resume
    for (int i = 0; i < 2 * PERIOD && m_presc != 2; i++) step("align");
    check("align_presc2", m_presc, 2);
    run = 1'b0;
    repeat (10) step("paused");
`ifndef LED_SEQ_PWM_EN
    prev_led = led;
`endif
    run = 1'b1;
    n = 0;
    step("resume"); n++;
`ifndef LED_SEQ_PWM_EN
    while (led === prev_led && n < 20) begin step("resume"); n++; end
    check("resume_latency", n, 2);
`endif

    // Tick coinciding with a HOLD request: the tick must be lost
    for (int i = 0; i < 2 * PERIOD && !(m_in_run != 0 && m_presc == PERIOD - 1); i++)
      step("align_tick");
    prev_led = 16'(m_led);
    request(2'd3, 0);
    check("hold_keeps_led", m_led, {16'h0, prev_led});
    repeat (3 * PERIOD) step("hold");

    // Random run toggling and mode requests
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) run = ~run;
      if ($urandom_range(0, 24) == 0)
        request(2'($urandom_range(0, 3)), $urandom_range(0, 3));
      else
        step("rand");
    end

    // Reset while in ACK; requester keeps mode_req asserted through it
    mode_sel = 2'd2;
    mode_req = 1'b1;
    for (int i = 0; i < 6 && mode_ack !== 1'b1; i++) step("pre_rst");
    check("in_ack_before_reset", {31'h0, mode_ack}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_switch");
    check("fresh_switch_busy", {31'h0, busy}, 32'd1);
    step("post_rst_ack");
    mode_req = 1'b0;
    run = 1'b1;
    repeat (2 * PERIOD + 2) step("post_rst_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
